// File: rtl/thread_scheduler.sv
// thread_scheduler: round-robin fetch sequencer holding one PC per hardware thread,
// issuing at most one instruction in flight per thread with retire-driven release/redirect.
module thread_scheduler #(
   parameter int PC_WIDTH = 8,
   parameter int THREAD_INDEX_BITS = 3,
   localparam int NUM_THREADS = 2**THREAD_INDEX_BITS
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_THREADS-1:0]              thread_enable,
   input  logic                                start_valid,
   input  logic [THREAD_INDEX_BITS-1:0]        start_thread,
   input  logic [PC_WIDTH-1:0]                 start_pc,
   input  logic                                fetch_ready,
   output logic                                fetch_valid,
   output logic [THREAD_INDEX_BITS-1:0]        fetch_thread,
   output logic [PC_WIDTH-1:0]                 fetch_pc,
   output logic [THREAD_INDEX_BITS+PC_WIDTH-1:0] instr_mem_pc,
   input  logic                                retire_valid,
   input  logic [THREAD_INDEX_BITS-1:0]        retire_thread,
   input  logic                                retire_redirect,
   input  logic [PC_WIDTH-1:0]                 retire_target,
   output logic [NUM_THREADS-1:0]              inflight
);
   logic [PC_WIDTH-1:0] pc [NUM_THREADS];
   logic [PC_WIDTH-1:0] pc_next [NUM_THREADS];
   logic [NUM_THREADS-1:0] elig, inflight_next;
   logic [THREAD_INDEX_BITS-1:0] ptr, sel, idx;
   logic found, adv, issue, retire_ok;

   assign adv = !fetch_valid || fetch_ready;
   assign elig = thread_enable & ~inflight;
   assign issue = adv && found;
   assign retire_ok = retire_valid && inflight[retire_thread];
   assign instr_mem_pc = {fetch_thread, fetch_pc};

   // Scan from farthest to nearest so the nearest eligible thread after ptr wins.
   always_comb begin
      found = 1'b0;
      sel = ptr;
      idx = ptr;
      for (int i = NUM_THREADS; i >= 1; i--) begin
         idx = ptr + THREAD_INDEX_BITS'(i);
         if (elig[idx]) begin
            found = 1'b1;
            sel = idx;
         end
      end
   end

   always_comb begin
      inflight_next = inflight;
      if (retire_ok) inflight_next[retire_thread] = 1'b0;
      if (issue) inflight_next[sel] = 1'b1;
      for (int t = 0; t < NUM_THREADS; t++)
         pc_next[t] = (start_valid && start_thread == THREAD_INDEX_BITS'(t)) ? start_pc
                    : (retire_ok && retire_redirect && retire_thread == THREAD_INDEX_BITS'(t)) ? retire_target
                    : (issue && sel == THREAD_INDEX_BITS'(t)) ? pc[t] + 1'b1
                    : pc[t];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int t = 0; t < NUM_THREADS; t++) pc[t] <= '0;
         inflight <= '0;
         fetch_valid <= 1'b0;
         fetch_thread <= '0;
         fetch_pc <= '0;
         ptr <= '1;
      end else begin
         for (int t = 0; t < NUM_THREADS; t++) pc[t] <= pc_next[t];
         inflight <= inflight_next;
         if (adv) fetch_valid <= found;
         if (issue) begin
            fetch_thread <= sel;
            fetch_pc <= pc[sel];
            ptr <= sel;
         end
      end
   end
endmodule
